// File: rtl/cam_pkg.sv
// Shared definitions for the CAM match counter: geometry, widths and FSM states.
// Latency: none (package only).
// Backpressure: none (package only).
package cam_pkg;

  // Default number of CAM rows. The legal range is 1..15, so a 4-bit count cannot overflow.
  localparam int N_ENTRIES = 8;

  // Count width. This matches the 4-bit fulladd datapath.
  localparam int CNT_W = 4;

  // Row index width. It covers the full 1..15 row range.
  localparam int IDX_W = 4;

  // Width of the reported first-hit row index.
  localparam int FH_W = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/fulladd.sv
// 4-bit adder with carry-in and carry-out. It is the accumulation datapath of the match counter.
// Latency: combinational.
// Backpressure: none.
// Ports: a, b   - 4-bit operands
//        c_in   - carry in
//        sum    - 4-bit sum
//        c_out  - carry out
module fulladd (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       c_in,
  output logic [3:0] sum,
  output logic       c_out
);

  logic [4:0] total;

  assign total = {1'b0, a} + {1'b0, b} + {4'b0000, c_in};
  assign sum   = total[3:0];
  assign c_out = total[4];

endmodule

// File: rtl/cam_match_counter.sv
// Counts the set bits of a captured CAM match vector and reports the lowest matching row.
// Latency: start sampled at edge E0 gives a one-cycle done pulse after edge E(N_ENTRIES).
// Backpressure: none. A start request while busy is dropped, so the caller must wait for done.
// Ports: clk, rst (async, active-high), start, match_vec[N_ENTRIES]
//        busy, done, count[CNT_W], hit, first_hit[3]
module cam_match_counter #(
  parameter int N_ENTRIES = cam_pkg::N_ENTRIES,
  parameter int CNT_W     = cam_pkg::CNT_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [N_ENTRIES-1:0] match_vec,
  output logic                 busy,
  output logic                 done,
  output logic [CNT_W-1:0]     count,
  output logic                 hit,
  output logic [2:0]           first_hit
);

  import cam_pkg::*;

  state_t                 state_q, state_d;
  logic [N_ENTRIES-1:0]   vec_q, vec_d;
  logic [CNT_W-1:0]       acc_q, acc_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic                   hit_q, hit_d;
  logic [FH_W-1:0]        fh_q, fh_d;

  logic                   cur_bit;
  logic                   last_row;
  logic [3:0]             add_sum;
  // With at most 15 rows, the carry-out cannot fire.
  logic                   add_cout_unused;

  // Row select is a compare loop. This avoids indexing an N-bit vector with a wider index.
  always_comb begin
    cur_bit = 1'b0;
    for (int i = 0; i < N_ENTRIES; i++) begin
      if (idx_q == IDX_W'(i)) begin
        cur_bit = vec_q[i];
      end
    end
  end

  assign last_row = (idx_q == IDX_W'(N_ENTRIES - 1));

  // Each row adds its match bit through the carry-in, with b tied to zero.
  fulladd u_add (
    .a     (acc_q),
    .b     (4'b0000),
    .c_in  (cur_bit),
    .sum   (add_sum),
    .c_out (add_cout_unused)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = SCAN;
      SCAN:    if (last_row) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic. Everything is decoded from registers only.
  always_comb begin
    busy = (state_q != IDLE);
    done = (state_q == DONE);
  end

  assign count     = acc_q;
  assign hit       = hit_q;
  assign first_hit = fh_q;

  // Datapath next-state. The results hold in DONE and IDLE until a new start is accepted.
  always_comb begin
    vec_d = vec_q;
    acc_d = acc_q;
    idx_d = idx_q;
    hit_d = hit_q;
    fh_d  = fh_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          vec_d = match_vec;
          acc_d = '0;
          idx_d = '0;
          hit_d = 1'b0;
          fh_d  = '0;
        end
      end
      SCAN: begin
        acc_d = add_sum;
        idx_d = idx_q + IDX_W'(1);
        // Only the first set row claims first_hit.
        if (cur_bit && !hit_q) begin
          hit_d = 1'b1;
          fh_d  = idx_q[FH_W-1:0];
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vec_q <= '0;
      acc_q <= '0;
      idx_q <= '0;
      hit_q <= 1'b0;
      fh_q  <= '0;
    end else begin
      vec_q <= vec_d;
      acc_q <= acc_d;
      idx_q <= idx_d;
      hit_q <= hit_d;
      fh_q  <= fh_d;
    end
  end

endmodule

// File: tb/tb_cam_match_counter.sv
// Directed testbench for cam_match_counter. It drives scans and compares the results against hand-computed values.
// Latency: done is expected N_ENTRIES edges after the start-sampling edge.
// Backpressure: start is only driven while the block is idle, except in the ignored-start and back-to-back scenarios.
module tb_cam_match_counter;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] match_vec;
  logic       busy;
  logic       done;
  logic [3:0] count;
  logic       hit;
  logic [2:0] first_hit;

  int passed;
  int total;
  int cout_seen;

  cam_match_counter #(
    .N_ENTRIES (8),
    .CNT_W     (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .match_vec (match_vec),
    .busy      (busy),
    .done      (done),
    .count     (count),
    .hit       (hit),
    .first_hit (first_hit)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Adder carry-out watch. It must never be seen high.
  always @(negedge clk) begin
    if (dut.add_cout_unused === 1'b1) cout_seen++;
  end

  // Starts one scan and waits for done. cyc counts negedges after the sampling edge.
  task automatic run_scan(input logic [7:0] mv, output int cyc, output bit timed_out);
    @(negedge clk);
    match_vec = mv;
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc   = 0;
    while (done !== 1'b1 && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    timed_out = (done !== 1'b1);
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; match_vec = 8'h00;
    #1;
    total++; if (busy !== 1'b0)      $display("FAIL reset_busy: got %b want 0", busy); else passed++;
    total++; if (done !== 1'b0)      $display("FAIL reset_done: got %b want 0", done); else passed++;
    total++; if (count !== 4'd0)     $display("FAIL reset_count: got %0d want 0", count); else passed++;
    total++; if (hit !== 1'b0)       $display("FAIL reset_hit: got %b want 0", hit); else passed++;
    total++; if (first_hit !== 3'd0) $display("FAIL reset_first_hit: got %0d want 0", first_hit); else passed++;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_zero;
    int cyc; bit to;
    run_scan(8'h00, cyc, to);
    total++; if (to)             $display("FAIL zero_timeout: no done within 40 cycles"); else passed++;
    total++; if (cyc != 8)       $display("FAIL zero_latency: got %0d want 8", cyc); else passed++;
    total++; if (count !== 4'd0) $display("FAIL zero_count: got %0d want 0", count); else passed++;
    total++; if (hit !== 1'b0)   $display("FAIL zero_hit: got %b want 0", hit); else passed++;
    total++; if (first_hit !== 3'd0) $display("FAIL zero_first_hit: got %0d want 0", first_hit); else passed++;
    @(negedge clk);
    total++; if (done !== 1'b0)  $display("FAIL zero_done_pulse: got %b want 0", done); else passed++;
    total++; if (busy !== 1'b0)  $display("FAIL zero_idle_busy: got %b want 0", busy); else passed++;
  endtask

  task automatic test_all_ones;
    int cyc; bit to;
    run_scan(8'hFF, cyc, to);
    total++; if (to)                 $display("FAIL ones_timeout: no done within 40 cycles"); else passed++;
    total++; if (count !== 4'd8)     $display("FAIL ones_count: got %0d want 8", count); else passed++;
    total++; if (hit !== 1'b1)       $display("FAIL ones_hit: got %b want 1", hit); else passed++;
    total++; if (first_hit !== 3'd0) $display("FAIL ones_first_hit: got %0d want 0", first_hit); else passed++;
    total++; if (cout_seen != 0)     $display("FAIL ones_cout: carry-out seen %0d times want 0", cout_seen); else passed++;
  endtask

  task automatic test_capture;
    int cyc;
    @(negedge clk);
    match_vec = 8'b1010_0100;
    start     = 1'b1;
    @(negedge clk);
    start     = 1'b0;
    match_vec = 8'h00;  // changes after capture must not matter
    cyc = 0;
    while (done !== 1'b1 && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (cyc == 3) match_vec = 8'hFF;
    end
    total++; if (done !== 1'b1)      $display("FAIL cap_timeout: no done within 40 cycles"); else passed++;
    total++; if (count !== 4'd3)     $display("FAIL cap_count: got %0d want 3", count); else passed++;
    total++; if (first_hit !== 3'd2) $display("FAIL cap_first_hit: got %0d want 2", first_hit); else passed++;
    total++; if (hit !== 1'b1)       $display("FAIL cap_hit: got %b want 1", hit); else passed++;
    // Results hold in IDLE while match_vec keeps moving.
    repeat (4) @(negedge clk);
    match_vec = 8'h5A;
    @(negedge clk);
    total++; if (count !== 4'd3)     $display("FAIL cap_hold_count: got %0d want 3", count); else passed++;
    total++; if (first_hit !== 3'd2) $display("FAIL cap_hold_first_hit: got %0d want 2", first_hit); else passed++;
  endtask

  task automatic test_start_ignored;
    int ndone; int cyc; bit to;
    @(negedge clk);
    match_vec = 8'h30;
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    match_vec = 8'h80;
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
    ndone = 0;
    repeat (14) begin
      @(negedge clk);
      if (done === 1'b1) ndone++;
    end
    total++; if (ndone != 1)         $display("FAIL ign_done_count: got %0d want 1", ndone); else passed++;
    total++; if (count !== 4'd2)     $display("FAIL ign_count: got %0d want 2", count); else passed++;
    total++; if (first_hit !== 3'd4) $display("FAIL ign_first_hit: got %0d want 4", first_hit); else passed++;
    run_scan(8'h80, cyc, to);
    total++; if (to)                 $display("FAIL ign_next_timeout: no done within 40 cycles"); else passed++;
    total++; if (count !== 4'd1)     $display("FAIL ign_next_count: got %0d want 1", count); else passed++;
    total++; if (first_hit !== 3'd7) $display("FAIL ign_next_first_hit: got %0d want 7", first_hit); else passed++;
  endtask

  task automatic test_reset_mid_scan;
    int ndone; int cyc; bit to;
    @(negedge clk);
    match_vec = 8'hFF;
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    total++; if (busy !== 1'b0)      $display("FAIL rstmid_busy: got %b want 0", busy); else passed++;
    total++; if (count !== 4'd0)     $display("FAIL rstmid_count: got %0d want 0", count); else passed++;
    total++; if (hit !== 1'b0)       $display("FAIL rstmid_hit: got %b want 0", hit); else passed++;
    total++; if (first_hit !== 3'd0) $display("FAIL rstmid_first_hit: got %0d want 0", first_hit); else passed++;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    ndone = 0;
    repeat (12) begin
      @(negedge clk);
      if (done === 1'b1) ndone++;
    end
    total++; if (ndone != 0)         $display("FAIL rstmid_no_done: got %0d pulses want 0", ndone); else passed++;
    run_scan(8'h81, cyc, to);
    total++; if (to)                 $display("FAIL rstmid_next_timeout: no done within 40 cycles"); else passed++;
    total++; if (cyc != 8)           $display("FAIL rstmid_next_latency: got %0d want 8", cyc); else passed++;
    total++; if (count !== 4'd2)     $display("FAIL rstmid_next_count: got %0d want 2", count); else passed++;
    total++; if (first_hit !== 3'd0) $display("FAIL rstmid_next_first_hit: got %0d want 0", first_hit); else passed++;
  endtask

  task automatic test_back_to_back;
    int pulse_at[$];
    int cyc;
    @(negedge clk);
    match_vec = 8'h0F;
    start     = 1'b1;
    cyc = 0;
    repeat (45) begin
      @(negedge clk);
      cyc++;
      if (done === 1'b1) begin
        pulse_at.push_back(cyc);
        total++; if (count !== 4'd4) $display("FAIL b2b_count: pulse %0d got %0d want 4", pulse_at.size(), count); else passed++;
      end
    end
    start = 1'b0;
    total++; if (pulse_at.size() != 4) $display("FAIL b2b_pulses: got %0d want 4", pulse_at.size()); else passed++;
    if (pulse_at.size() == 4) begin
      total++; if (pulse_at[0] != 9) $display("FAIL b2b_first: got %0d want 9", pulse_at[0]); else passed++;
      for (int k = 1; k < 4; k++) begin
        total++;
        if (pulse_at[k] - pulse_at[k-1] != 10)
          $display("FAIL b2b_period: gap %0d got %0d want 10", k, pulse_at[k] - pulse_at[k-1]);
        else passed++;
      end
    end
    repeat (12) @(negedge clk);
    total++; if (busy !== 1'b0)  $display("FAIL b2b_settle_busy: got %b want 0", busy); else passed++;
    total++; if (cout_seen != 0) $display("FAIL final_cout: carry-out seen %0d times want 0", cout_seen); else passed++;
  endtask

  initial begin
    passed = 0;
    total = 0;
    cout_seen = 0;
    test_reset;
    test_zero;
    test_all_ones;
    test_capture;
    test_start_ignored;
    test_reset_mid_scan;
    test_back_to_back;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/cam_match_counter.md
CAM_MATCH_COUNTER -- requirements
Module: cam_match_counter

Interface
REQ-001 Parameter N_ENTRIES, default 8, SHALL set the number of CAM rows (match vector width); legal range 1..15.
REQ-002 Parameter CNT_W, default 4, SHALL set the count width; fixed at 4 to match the 4-bit adder.
REQ-003 Port clk  input  1  SHALL be the single clock; all state updates on the rising edge.
REQ-004 Port rst  input  1  SHALL be the reset: asynchronous, active-high.
REQ-005 Port start  input  1  SHALL request a count of match_vec; sampled only in IDLE.
REQ-006 Port match_vec  input  N_ENTRIES  SHALL carry the per-row match lines from the 8x4 associative array.
REQ-007 Port busy  output  1  SHALL be high in SCAN and DONE.
REQ-008 Port done  output  1  SHALL be a single-cycle pulse marking valid results.
REQ-009 Port count  output  CNT_W  SHALL give the number of set match_vec bits.
REQ-010 Port hit  output  1  SHALL be high when count is non-zero.
REQ-011 Port first_hit  output  3  SHALL give the lowest matching row index; 0 when hit is low.

Function
REQ-012 The FSM SHALL have states IDLE, SCAN and DONE.
REQ-013 In IDLE with start high, the block SHALL capture match_vec into an internal register and clear the accumulator, index, hit flag and first-hit register at the same edge.
REQ-014 The block SHALL move from IDLE to SCAN on that edge; start in any other state SHALL be ignored with no effect.
REQ-015 In SCAN, the block SHALL process one row per cycle in index order 0..N_ENTRIES-1.
REQ-016 Each SCAN edge SHALL update the accumulator with the fulladd sum for a=accumulator, b=0, c_in=captured bit[index].
REQ-017 The first SCAN edge on a set bit SHALL load first_hit with its index and set hit; later set bits SHALL NOT change first_hit.
REQ-018 After the edge that processes index N_ENTRIES-1, the FSM SHALL enter DONE.
REQ-019 done SHALL be high for exactly the one cycle spent in DONE; the FSM then SHALL return to IDLE.
REQ-020 Latency: start sampled at edge E0 SHALL produce done high between edges E8 and E9 (N_ENTRIES+1 edges).
REQ-021 count, hit and first_hit SHALL remain stable from DONE until the next accepted start, including while in IDLE.
REQ-022 Changes on match_vec after capture SHALL NOT affect the result in progress.
REQ-023 The adder c_out SHALL be unused; it is always 0 for N_ENTRIES<=15, and the bench checks this by assertion.
REQ-024 start held high continuously SHALL start back-to-back scans, one per N_ENTRIES+2 cycles.

Reset
REQ-025 Asserting rst SHALL immediately force the FSM to IDLE and drive busy=0, done=0, count=0, hit=0, first_hit=0, independent of clk.
REQ-026 rst asserted mid-SCAN SHALL abort the scan with no done pulse; the first start after release SHALL begin a fresh scan.
REQ-027 Outputs SHALL be registered; no output SHALL depend combinationally on start or match_vec.

Structure
REQ-028 A shared package cam_pkg SHALL hold N_ENTRIES, CNT_W, the row-index width and the FSM state enum (IDLE, SCAN, DONE).
REQ-029 The block SHALL instantiate the existing 4-bit fulladd as its single sub-module for the accumulation datapath; no other arithmetic operator SHALL be used for count.

Verification
REQ-030 Reset, then start with match_vec=8'h00 SHALL give done at cycle 9 with count=0, hit=0, first_hit=0.
REQ-031 match_vec=8'hFF SHALL give count=8, hit=1, first_hit=0, with c_out never asserted.
REQ-032 match_vec=8'b1010_0100 SHALL give count=3, first_hit=2; toggling match_vec to 8'h00 during SCAN SHALL leave the result unchanged.
REQ-033 Pulsing start again during SCAN with match_vec=8'h80 SHALL be ignored: exactly one done and the original result; a following start in IDLE SHALL give count=1, first_hit=7.
REQ-034 Asserting rst at SCAN cycle 4 of an 8'hFF scan SHALL clear all outputs asynchronously with no done; a new start with 8'h81 SHALL then give count=2, first_hit=0.
REQ-035 Holding start high with 8'h0F SHALL give done pulses every 10 cycles, each with count=4.
